rc5_core_param: RTL and testbench

Parametrised RC5 block-cipher engine. It processes one 2W-bit block per transaction and runs R full rounds. Encrypt or decrypt is selected per block, and the 2R+2-entry subkey table is loadable at run time. It replaces the fixed 16-bit, single-round, encrypt-only engine in the crypto datapath, and it moves block transfers onto a valid/ready handshake with back-pressure.

---
 rtl/rc5_core_param.sv | 162 ++++++++++++++++
 tb/tb_rc5_core_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_core_param.sv
// rc5_core_param: RC5 block-cipher engine, W-bit words, R rounds, encrypt or
// decrypt per block, run-time subkey table, valid/ready handshake on both sides.
module rc5_core_param #(
  parameter int W = 8,
  parameter int R = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [2*W-1:0]           i_din,
  input  logic                     i_dec,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [2*W-1:0]           o_dout,
  input  logic                     i_key_we,
  input  logic [$clog2(2*R+2)-1:0] i_key_addr,
  input  logic [W-1:0]             i_key_data,
  output logic                     o_key_err
);
  localparam int T  = 2*R + 2;
  localparam int AW = $clog2(T);
  localparam int IW = $clog2(R + 2);
  localparam int LW = $clog2(W);

  if (!(W == 8 || W == 16 || W == 32)) begin : g_bad_w
    $error("rc5_core_param: W must be 8, 16 or 32");
  end
  if (R < 1 || R > 15) begin : g_bad_r
    $error("rc5_core_param: R must be in 1..15");
  end

  // state        | meaning
  // S_IDLE       | waiting for a block; only state that takes key writes
  // S_ENC_WHITEN | encrypt pre-whitening with S[0], S[1]
  // S_ROUND_A    | A half-round (encrypt first, decrypt second)
  // S_ROUND_B    | B half-round (encrypt second, decrypt first)
  // S_DEC_WHITEN | decrypt post-whitening, loads dout
  // S_HOLD       | result presented until out_ready
  typedef enum logic [2:0] {
    S_IDLE, S_ENC_WHITEN, S_ROUND_A, S_ROUND_B, S_DEC_WHITEN, S_HOLD
  } state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b;
  logic [IW-1:0]   r_i;
  logic            r_dec;
  logic [2*W-1:0]  r_dout;
  logic            r_key_err;
  logic [W-1:0]    r_s [T];

  logic [AW-1:0]   w_ka, w_kb;
  logic [W-1:0]    w_a_enc, w_b_enc, w_a_dec, w_b_dec;
  logic            w_last_enc, w_last_dec, w_accept, w_addr_ok, w_key_ok;

  function automatic logic [W-1:0] f_rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] f_rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  assign w_ka       = AW'({r_i, 1'b0});
  assign w_kb       = AW'({r_i, 1'b1});
  assign w_a_enc    = f_rotl(r_a ^ r_b, r_b[LW-1:0]) + r_s[w_ka];
  assign w_b_enc    = f_rotl(r_b ^ r_a, r_a[LW-1:0]) + r_s[w_kb];
  assign w_b_dec    = f_rotr(r_b - r_s[w_kb], r_a[LW-1:0]) ^ r_a;
  assign w_a_dec    = f_rotr(r_a - r_s[w_ka], r_b[LW-1:0]) ^ r_b;
  assign w_last_enc = (r_i >= IW'(R));
  assign w_last_dec = (r_i <= IW'(1));
  assign w_accept   = (r_state == S_IDLE) && i_in_valid;
  assign w_addr_ok  = (32'(i_key_addr) < 32'(T));
  assign w_key_ok   = i_key_we && (r_state == S_IDLE) && w_addr_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (i_in_valid) w_next = i_dec ? S_ROUND_B : S_ENC_WHITEN;
      S_ENC_WHITEN: w_next = S_ROUND_A;
      S_ROUND_A:    w_next = (r_dec && w_last_dec) ? S_DEC_WHITEN : S_ROUND_B;
      S_ROUND_B:    w_next = (!r_dec && w_last_enc) ? S_HOLD : S_ROUND_A;
      S_DEC_WHITEN: w_next = S_HOLD;
      S_HOLD:       if (i_out_ready) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_i    <= '0;
      r_dec  <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a   <= i_din[2*W-1:W];
          r_b   <= i_din[W-1:0];
          r_dec <= i_dec;
          r_i   <= i_dec ? IW'(R) : IW'(1);
        end
        S_ENC_WHITEN: begin
          r_a <= r_a + r_s[0];
          r_b <= r_b + r_s[1];
          r_i <= IW'(1);
        end
        S_ROUND_A: begin
          if (r_dec) begin
            r_a <= w_a_dec;
            r_i <= r_i - IW'(1);
          end else begin
            r_a <= w_a_enc;
          end
        end
        S_ROUND_B: begin
          if (r_dec) begin
            r_b <= w_b_dec;
          end else begin
            r_b <= w_b_enc;
            r_i <= r_i + IW'(1);
            if (w_last_enc) r_dout <= {r_a, w_b_enc};
          end
        end
        S_DEC_WHITEN: begin
          r_a    <= r_a - r_s[0];
          r_b    <= r_b - r_s[1];
          r_dout <= {r_a - r_s[0], r_b - r_s[1]};
        end
        default: ;
      endcase
    end
  end

  // Subkey table: writes land only in IDLE; a write on the accept edge is
  // still taken because the first key read is a cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < T; k++) r_s[k] <= '0;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= i_key_we && !w_key_ok;
      if (w_key_ok) r_s[i_key_addr] <= i_key_data;
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_HOLD);
  assign o_dout      = r_dout;
  assign o_key_err   = r_key_err;

endmodule

// File: tb/tb_rc5_core_param.sv
// Self-checking bench for rc5_core_param: directed W=8/R=1 vectors plus a
// random W=16/R=12 round-trip regression against a behavioural RC5 model.
module tb_rc5_core_param;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        v8, rdy8, dec8, ov8, ordy8, kwe8, kerr8;
  logic [15:0] din8, dout8;
  logic [1:0]  ka8;
  logic [7:0]  kd8;
  logic        v16, rdy16, dec16, ov16, ordy16, kwe16, kerr16;
  logic [31:0] din16, dout16;
  logic [4:0]  ka16;
  logic [15:0] kd16;

  logic [31:0] s8 [32];
  logic [31:0] s16 [32];

  rc5_core_param #(.W(8), .R(1)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v8), .o_in_ready(rdy8),
    .i_din(din8), .i_dec(dec8), .o_out_valid(ov8), .i_out_ready(ordy8),
    .o_dout(dout8), .i_key_we(kwe8), .i_key_addr(ka8), .i_key_data(kd8),
    .o_key_err(kerr8));

  rc5_core_param #(.W(16), .R(12)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v16), .o_in_ready(rdy16),
    .i_din(din16), .i_dec(dec16), .o_out_valid(ov16), .i_out_ready(ordy16),
    .o_dout(dout16), .i_key_we(kwe16), .i_key_addr(ka16), .i_key_data(kd16),
    .o_key_err(kerr16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RC5 on plain integers, any word width up to 32.
  function automatic logic [31:0] msk(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] rotl_m(input logic [31:0] x, input logic [31:0] n, input int w);
    int s;
    s = int'(n % 32'(w));
    if (s == 0) return x & msk(w);
    return ((x << s) | (x >> (w - s))) & msk(w);
  endfunction

  function automatic logic [31:0] rotr_m(input logic [31:0] x, input logic [31:0] n, input int w);
    int s;
    s = int'(n % 32'(w));
    if (s == 0) return x & msk(w);
    return ((x >> s) | (x << (w - s))) & msk(w);
  endfunction

  function automatic logic [63:0] rc5_m(input logic dec, input logic [31:0] a0, input logic [31:0] b0,
                                        input int w, input int r, input logic [31:0] s [32]);
    logic [31:0] a, b, m;
    m = msk(w);
    a = a0;
    b = b0;
    if (!dec) begin
      a = (a + s[0]) & m;
      b = (b + s[1]) & m;
      for (int i = 1; i <= r; i++) begin
        a = (rotl_m(a ^ b, b, w) + s[2*i]) & m;
        b = (rotl_m(b ^ a, a, w) + s[2*i+1]) & m;
      end
    end else begin
      for (int i = r; i >= 1; i--) begin
        b = rotr_m((b - s[2*i+1]) & m, a, w) ^ a;
        a = rotr_m((a - s[2*i]) & m, b, w) ^ b;
      end
      b = (b - s[1]) & m;
      a = (a - s[0]) & m;
    end
    return {a, b};
  endfunction

  function automatic logic [15:0] e8(input logic d, input logic [15:0] x);
    logic [63:0] res;
    res = rc5_m(d, {24'd0, x[15:8]}, {24'd0, x[7:0]}, 8, 1, s8);
    return {res[39:32], res[7:0]};
  endfunction

  function automatic logic [31:0] e16(input logic d, input logic [31:0] x);
    logic [63:0] res;
    res = rc5_m(d, {16'd0, x[31:16]}, {16'd0, x[15:0]}, 16, 12, s16);
    return {res[47:32], res[15:0]};
  endfunction

  task automatic load8(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk); kwe8 = 1'b1; ka8 = idx; kd8 = val;
    @(negedge clk); kwe8 = 1'b0;
    s8[idx] = {24'd0, val};
    chk("load8_key_err", 64'(kerr8), 64'(0));
  endtask

  task automatic load16(input logic [4:0] idx, input logic [15:0] val);
    @(negedge clk); kwe16 = 1'b1; ka16 = idx; kd16 = val;
    @(negedge clk); kwe16 = 1'b0;
    s16[idx] = {16'd0, val};
  endtask

  task automatic start8(input logic d, input logic [15:0] x);
    @(negedge clk); v8 = 1'b1; dec8 = d; din8 = x;
    @(posedge clk); #1; v8 = 1'b0; dec8 = ~d; din8 = 16'($urandom);
  endtask

  task automatic wait8(output logic [15:0] y, output int lat);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    y = dout8;
  endtask

  task automatic run8(input logic d, input logic [15:0] x, output logic [15:0] y, output int lat);
    start8(d, x);
    wait8(y, lat);
  endtask

  task automatic retire8();
    @(negedge clk); ordy8 = 1'b1; v8 = 1'b0;
    @(negedge clk); ordy8 = 1'b0;
    chk("retire8_in_ready", 64'(rdy8), 64'(1));
    chk("retire8_out_valid", 64'(ov8), 64'(0));
  endtask

  task automatic run16(input logic d, input logic [31:0] x, output logic [31:0] y, output int lat);
    @(negedge clk); v16 = 1'b1; dec16 = d; din16 = x;
    @(posedge clk); #1; v16 = 1'b0; dec16 = ~d;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    y = dout16;
    @(negedge clk); ordy16 = 1'b1;
    @(negedge clk); ordy16 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] y8, x8, p8;
    logic [31:0] x32, y32, z32;
    int lat;
    v8 = 0; dec8 = 0; ordy8 = 0; kwe8 = 0; din8 = '0; ka8 = '0; kd8 = '0;
    v16 = 0; dec16 = 0; ordy16 = 0; kwe16 = 0; din16 = '0; ka16 = '0; kd16 = '0;
    for (int k = 0; k < 32; k++) begin s8[k] = '0; s16[k] = '0; end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(rdy8), 64'(1));
    chk("rst_out_valid", 64'(ov8), 64'(0));
    chk("rst_dout", 64'(dout8), 64'(0));
    chk("rst_key_err", 64'(kerr8), 64'(0));
    rst_n = 1'b1;

    load8(2'd0, 8'h20); load8(2'd1, 8'h10); load8(2'd2, 8'hFF); load8(2'd3, 8'hFF);
    run8(1'b0, 16'h0000, y8, lat);
    chk("enc_0000", 64'(y8), 64'(16'h2F9E));
    chk("enc_0000_model", 64'(y8), 64'(e8(1'b0, 16'h0000)));
    chk("enc_0000_lat", 64'(lat), 64'(3));
    retire8();
    run8(1'b0, 16'h1234, y8, lat);
    chk("enc_1234", 64'(y8), 64'(16'h6687));
    chk("enc_1234_lat", 64'(lat), 64'(3));
    retire8();
    run8(1'b1, 16'h6687, y8, lat);
    chk("dec_6687", 64'(y8), 64'(16'h1234));
    chk("dec_6687_lat", 64'(lat), 64'(3));
    retire8();
    ordy8 = 1'b1;  // out_ready high while nothing is valid must not disturb the block
    run8(1'b1, 16'h2F9E, y8, lat);
    chk("dec_2f9e", 64'(y8), 64'(16'h0000));
    chk("dec_2f9e_lat", 64'(lat), 64'(3));
    retire8();

    for (int n = 0; n < 6; n++) begin
      x8 = 16'($urandom);
      run8(1'b0, x8, y8, lat);
      chk("rnd8_enc", 64'(y8), 64'(e8(1'b0, x8)));
      retire8();
      run8(1'b1, y8, p8, lat);
      chk("rnd8_dec", 64'(p8), 64'(x8));
      retire8();
    end

    run8(1'b0, 16'h1234, y8, lat);
    v8 = 1'b1; din8 = 16'h0000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_dout", 64'(dout8), 64'(16'h6687));
      chk("bp_in_ready", 64'(rdy8), 64'(0));
      chk("bp_out_valid", 64'(ov8), 64'(1));
    end
    retire8();

    @(negedge clk); v8 = 1'b1; dec8 = 1'b0; din8 = 16'h0000;
    @(posedge clk); #1; v8 = 1'b0;
    @(posedge clk); #1; kwe8 = 1'b1; ka8 = 2'd2; kd8 = 8'h00;
    @(posedge clk); #1; kwe8 = 1'b0;
    chk("kerr_busy", 64'(kerr8), 64'(1));
    @(posedge clk); #1;
    chk("kerr_busy_end", 64'(kerr8), 64'(0));
    chk("busy_out_valid", 64'(ov8), 64'(1));
    chk("busy_dout", 64'(dout8), 64'(16'h2F9E));
    retire8();
    run8(1'b0, 16'h0000, y8, lat);
    chk("table_kept", 64'(y8), 64'(16'h2F9E));
    retire8();

    @(negedge clk); v8 = 1'b1; dec8 = 1'b0; din8 = 16'h1234; kwe8 = 1'b1; ka8 = 2'd0; kd8 = 8'h21;
    @(posedge clk); #1; v8 = 1'b0; kwe8 = 1'b0;
    s8[0] = 32'h21;
    chk("same_edge_key_err", 64'(kerr8), 64'(0));
    wait8(y8, lat);
    chk("same_edge_result", 64'(y8), 64'(e8(1'b0, 16'h1234)));
    chk("same_edge_lat", 64'(lat), 64'(3));
    retire8();
    load8(2'd0, 8'h20);

    start8(1'b0, 16'h1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 32; k++) begin s8[k] = '0; s16[k] = '0; end
    #1;
    chk("midrst_out_valid", 64'(ov8), 64'(0));
    chk("midrst_dout", 64'(dout8), 64'(0));
    chk("midrst_in_ready", 64'(rdy8), 64'(1));
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_output", 64'(ov8), 64'(0));
    run8(1'b0, 16'h1234, y8, lat);
    chk("zero_key_enc", 64'(y8), 64'(e8(1'b0, 16'h1234)));
    retire8();
    load8(2'd0, 8'h20); load8(2'd1, 8'h10); load8(2'd2, 8'hFF); load8(2'd3, 8'hFF);
    run8(1'b0, 16'h0000, y8, lat);
    chk("reload_enc", 64'(y8), 64'(16'h2F9E));
    retire8();

    for (int k = 0; k < 26; k++) load16(5'(k), 16'($urandom));
    @(negedge clk); kwe16 = 1'b1; ka16 = 5'd26; kd16 = 16'hBEEF;
    @(posedge clk); #1; kwe16 = 1'b0;
    chk("kerr_addr_T", 64'(kerr16), 64'(1));
    @(posedge clk); #1;
    chk("kerr_addr_T_end", 64'(kerr16), 64'(0));

    for (int n = 0; n < 200; n++) begin
      x32 = $urandom;
      run16(1'b0, x32, y32, lat);
      chk("w16_enc", 64'(y32), 64'(e16(1'b0, x32)));
      chk("w16_enc_lat", 64'(lat), 64'(25));
      run16(1'b1, y32, z32, lat);
      chk("w16_roundtrip", 64'(z32), 64'(x32));
      chk("w16_dec_lat", 64'(lat), 64'(25));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
